fetch_responder: RTL and testbench

- Consumer end of the fetch unit's issue handshake.
- Accepts (warp_id, pc) requests on s_tvalid/s_tready.
- Issues word reads to a fixed-latency instruction memory, then buffers the returned instruction with its warp_id/pc in a small FIFO.
- Presents the buffered entries to decode on m_tvalid/m_tready.
- Sits between fetch and decode; its s_tready is the backpressure signal the fetch unit waits on.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_responder_if.sv | 33 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/fetch_responder.sv | 98 +++++++++
 tb/tb_fetch_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and payload types for the fetch/decode boundary.
package fetch_pkg;

  localparam int WARP_ID_W   = 32;
  localparam int PC_W        = 32;
  localparam int INST_W      = 32;
  localparam int IMEM_AW     = 10;
  localparam int DEF_MEM_LAT = 2;
  localparam int DEF_DEPTH   = 4;

  typedef struct packed {
    logic [WARP_ID_W-1:0] warp_id;
    logic [PC_W-1:0]      pc;
  } fetch_req_t;

  typedef struct packed {
    logic [WARP_ID_W-1:0] warp_id;
    logic [PC_W-1:0]      pc;
    logic [INST_W-1:0]    inst;
    logic                 misalign;
  } fetch_rsp_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_responder_if.sv
// Fetch request, instruction memory and decode-side signals of the responder.
interface fetch_responder_if;
  import fetch_pkg::*;

  logic                 s_tvalid;
  logic                 s_tready;
  logic [WARP_ID_W-1:0] s_warp_id;
  logic [PC_W-1:0]      s_pc;

  logic                 imem_req_valid;
  logic [IMEM_AW-1:0]   imem_addr;
  logic [INST_W-1:0]    imem_rdata;

  logic                 m_tvalid;
  logic                 m_tready;
  logic [WARP_ID_W-1:0] m_warp_id;
  logic [PC_W-1:0]      m_pc;
  logic [INST_W-1:0]    m_inst;
  logic                 m_misalign;

  modport slave (
    input  s_tvalid, s_warp_id, s_pc, imem_rdata, m_tready,
    output s_tready, imem_req_valid, imem_addr,
           m_tvalid, m_warp_id, m_pc, m_inst, m_misalign
  );

  modport master (
    output s_tvalid, s_warp_id, s_pc, imem_rdata, m_tready,
    input  s_tready, imem_req_valid, imem_addr,
           m_tvalid, m_warp_id, m_pc, m_inst, m_misalign
  );

endinterface

// File: rtl/sync_fifo.sv
// Registered FIFO with occupancy count and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_responder.sv
// Accepts fetch requests, reads instruction memory through a tag pipeline and
// buffers responses for decode; credits reserve a FIFO slot for every read in flight.
module fetch_responder
  import fetch_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int DEPTH   = DEF_DEPTH
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  fetch_responder_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_req_t        req;
  fetch_req_t        tag_q [MEM_LAT];
  logic [MEM_LAT-1:0] tag_v;
  fetch_rsp_t        wr_rsp;
  fetch_rsp_t        head;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic [CW:0]       credit_sum;
  logic              accept;
  logic              last_v;
  logic              push;
  logic              pop;

  assign req        = '{warp_id: bus.s_warp_id, pc: bus.s_pc};
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};

  assign bus.s_tready       = !rst && !flush && (credit_sum < DEPTH_C);
  assign accept             = bus.s_tvalid && bus.s_tready;
  assign bus.imem_req_valid = accept;
  assign bus.imem_addr      = bus.s_pc[IMEM_AW+1:2];

  // The last tag stage lines up with the cycle its read data is on imem_rdata.
  assign last_v = tag_v[MEM_LAT-1];
  assign push   = last_v && !flush;
  assign wr_rsp = '{warp_id:  tag_q[MEM_LAT-1].warp_id,
                    pc:       tag_q[MEM_LAT-1].pc,
                    inst:     bus.imem_rdata,
                    misalign: is_misaligned(tag_q[MEM_LAT-1].pc[1:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
    end else if (flush) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= accept;
      if (accept) tag_q[0] <= req;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      case ({accept, last_v})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_rsp_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (wr_rsp),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign bus.m_tvalid   = (fifo_count != '0) && !flush;
  assign pop            = bus.m_tvalid && bus.m_tready;
  assign bus.m_warp_id  = head.warp_id;
  assign bus.m_pc       = head.pc;
  assign bus.m_inst     = head.inst;
  assign bus.m_misalign = head.misalign;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder with a fixed-latency instruction memory model.
module tb_fetch_responder;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fail;

  fetch_responder_if bus();

  fetch_responder dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [IMEM_AW-1:0] a);
    return (a == 10'd2) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, a});
  endfunction

  // Memory: data for the address strobed in cycle c appears in cycle c+MEM_LAT.
  logic [IMEM_AW-1:0] mq [DEF_MEM_LAT];
  always @(posedge clk) begin
    mq[0] <= bus.imem_addr;
    for (int i = 1; i < DEF_MEM_LAT; i++) mq[i] <= mq[i-1];
  end
  assign bus.imem_rdata = inst_of(mq[DEF_MEM_LAT-1]);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input int w, input int pc);
    bus.s_tvalid  = v;
    bus.s_warp_id = 32'(w);
    bus.s_pc      = 32'(pc);
  endtask

  int n_acc;
  int seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    bus.m_tready = 1'b0;
    drive_req(1'b1, 0, 'h1000);
    #1;
    check("rst_s_tready",  64'(bus.s_tready), 64'd0);
    check("rst_imem_req",  64'(bus.imem_req_valid), 64'd0);
    check("rst_m_tvalid",  64'(bus.m_tvalid), 64'd0);
    check("rst_m_warp_id", 64'(bus.m_warp_id), 64'd0);
    check("rst_m_pc",      64'(bus.m_pc), 64'd0);
    check("rst_m_inst",    64'(bus.m_inst), 64'd0);
    check("rst_m_misalign",64'(bus.m_misalign), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b0, 0, 0);
    tick();

    // single request
    drive_req(1'b1, 3, 'h1008);
    #1;
    check("single_s_tready", 64'(bus.s_tready), 64'd1);
    check("single_imem_req", 64'(bus.imem_req_valid), 64'd1);
    check("single_imem_addr", 64'(bus.imem_addr), 64'd2);
    tick();
    drive_req(1'b0, 0, 0);
    check("single_lat1", 64'(bus.m_tvalid), 64'd0);
    tick();
    check("single_lat2", 64'(bus.m_tvalid), 64'd0);
    tick();
    check("single_lat3", 64'(bus.m_tvalid), 64'd1);
    check("single_warp", 64'(bus.m_warp_id), 64'd3);
    check("single_pc",   64'(bus.m_pc), 64'h1008);
    check("single_inst", 64'(bus.m_inst), 64'hDEADBEEF);
    check("single_mis",  64'(bus.m_misalign), 64'd0);
    bus.m_tready = 1'b1;
    tick();
    check("single_popped", 64'(bus.m_tvalid), 64'd0);

    // back-to-back, response i shows up in loop cycle i+3
    for (int t = 0; t < 12; t++) begin
      drive_req(t < 8, t, 'h1000 + 4 * t);
      #1;
      if (t < 8) check("b2b_s_tready", 64'(bus.s_tready), 64'd1);
      check("b2b_m_tvalid", 64'(bus.m_tvalid), 64'(t >= 3 && t < 11));
      if (t >= 3 && t < 11) begin
        check("b2b_warp", 64'(bus.m_warp_id), 64'(t - 3));
        check("b2b_pc",   64'(bus.m_pc), 64'('h1000 + 4 * (t - 3)));
        check("b2b_inst", 64'(bus.m_inst), 64'(inst_of(10'(t - 3))));
      end
      tick();
    end
    drive_req(1'b0, 0, 0);
    tick();

    // backpressure: credits cap accepts at DEPTH
    bus.m_tready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive_req(1'b1, 10 + n_acc, 'h1100 + 4 * n_acc);
      #1;
      if (bus.s_tready) n_acc++;
      tick();
    end
    drive_req(1'b0, 0, 0);
    #1;
    check("bp_accepts",  64'(n_acc), 64'd4);
    check("bp_s_tready", 64'(bus.s_tready), 64'd0);
    check("bp_m_tvalid", 64'(bus.m_tvalid), 64'd1);
    tick();
    tick();
    check("bp_hold_warp", 64'(bus.m_warp_id), 64'd10);
    check("bp_hold_pc",   64'(bus.m_pc), 64'h1100);
    check("bp_hold_inst", 64'(bus.m_inst), 64'(inst_of(10'h040)));
    bus.m_tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("bp_drain_valid", 64'(bus.m_tvalid), 64'd1);
      check("bp_drain_warp",  64'(bus.m_warp_id), 64'(10 + j));
      check("bp_drain_pc",    64'(bus.m_pc), 64'('h1100 + 4 * j));
      check("bp_drain_inst",  64'(bus.m_inst), 64'(inst_of(10'(64 + j))));
      tick();
    end
    #1;
    check("bp_empty",    64'(bus.m_tvalid), 64'd0);
    check("bp_reopen",   64'(bus.s_tready), 64'd1);
    tick();

    // flush after two accepts
    drive_req(1'b1, 1, 'h2000);
    #1;
    check("fl_acc1", 64'(bus.s_tready), 64'd1);
    tick();
    drive_req(1'b1, 2, 'h2004);
    #1;
    check("fl_acc2", 64'(bus.s_tready), 64'd1);
    tick();
    drive_req(1'b0, 0, 0);
    flush = 1'b1;
    #1;
    check("fl_s_tready", 64'(bus.s_tready), 64'd0);
    check("fl_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_inflight", 64'(dut.inflight), 64'd0);
    check("fl_count",    64'(dut.fifo_count), 64'd0);
    check("fl_reopen",   64'(bus.s_tready), 64'd1);
    seen = 0;
    repeat (5) begin
      if (bus.m_tvalid) seen++;
      tick();
    end
    check("fl_no_output", 64'(seen), 64'd0);

    // misaligned pc
    drive_req(1'b1, 31, 'h1002);
    #1;
    check("mis_imem_addr", 64'(bus.imem_addr), 64'd0);
    tick();
    drive_req(1'b0, 0, 0);
    tick();
    tick();
    check("mis_valid", 64'(bus.m_tvalid), 64'd1);
    check("mis_flag",  64'(bus.m_misalign), 64'd1);
    check("mis_warp",  64'(bus.m_warp_id), 64'd31);
    check("mis_pc",    64'(bus.m_pc), 64'h1002);
    check("mis_inst",  64'(bus.m_inst), 64'hC0DE0000);
    tick();

    // async reset with three entries buffered
    bus.m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 20 + i, 'h3000 + 4 * i);
      tick();
    end
    drive_req(1'b0, 0, 0);
    repeat (3) tick();
    check("ar_buffered", 64'(dut.fifo_count), 64'd3);
    check("ar_m_tvalid_pre", 64'(bus.m_tvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check("ar_s_tready", 64'(bus.s_tready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.m_tready = 1'b1;
    drive_req(1'b1, 5, 'h1008);
    #1;
    check("ar_post_s_tready", 64'(bus.s_tready), 64'd1);
    check("ar_post_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    tick();
    drive_req(1'b0, 0, 0);
    tick();
    tick();
    check("ar_fresh_valid", 64'(bus.m_tvalid), 64'd1);
    check("ar_fresh_warp",  64'(bus.m_warp_id), 64'd5);
    check("ar_fresh_inst",  64'(bus.m_inst), 64'hDEADBEEF);
    tick();
    check("ar_fresh_popped", 64'(bus.m_tvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
